// File: rtl/pipeline_hazard_ctrl_if.sv
// Issue-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// The datapath presents the IF/ID instruction and the branch outcome; the controller returns the stage controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [19:0]      id_instruction;
  logic             id_valid;
  logic             ex_branch_taken;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_hold;
  logic             issue;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_instruction, id_valid, ex_branch_taken,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold, issue, stall_cycles
  );

  modport slave (
    input  id_instruction, id_valid, ex_branch_taken,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold, issue, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/issue controller: per-register write scoreboard, multi-cycle MUL sequencer,
// taken-branch flush and a saturating stall counter driving the PC, IF/ID and ID/EX controls.
module pipeline_hazard_ctrl #(
  parameter int NUM_REGS    = 8,
  parameter int WB_DISTANCE = 3,
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
);
  localparam int SB_W = $clog2(WB_DISTANCE + MUL_LATENCY);
  localparam int MC_W = $clog2(MUL_LATENCY);
  localparam logic [SB_W-1:0] LOAD_ALU = SB_W'(WB_DISTANCE);
  localparam logic [SB_W-1:0] LOAD_MUL = SB_W'(WB_DISTANCE + MUL_LATENCY - 1);
  localparam logic [MC_W-1:0] MCNT_INIT = MC_W'(MUL_LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [MC_W-1:0]  mcnt_reg, mcnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [3:0] opcode;
  logic [2:0] rd, rs1, rs2;
  logic       reads_rs1, reads_rs2, writes_rd, is_mul;
  logic [NUM_REGS-1:0] busy;
  logic       data_hazard, stall, flush, issue_int;

  assign opcode = bus.id_instruction[19:16];
  assign rd     = bus.id_instruction[15:13];
  assign rs1    = bus.id_instruction[12:10];
  assign rs2    = bus.id_instruction[9:7];

  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    is_mul    = 1'b0;
    case (opcode)
      4'd1:       begin reads_rs1 = 1'b1; writes_rd = 1'b1; end
      4'd2, 4'd6: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      4'd3, 4'd4: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; writes_rd = 1'b1; end
      4'd5:       begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; writes_rd = 1'b1; is_mul = 1'b1; end
      default:    ;
    endcase
  end

  // Each counter tracks cycles until its register's pending result is readable.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      logic [SB_W-1:0] cnt_reg;
      always_ff @(posedge clock) begin
        if (reset)
          cnt_reg <= '0;
        else if (issue_int && writes_rd && rd == 3'(gi))
          cnt_reg <= is_mul ? LOAD_MUL : LOAD_ALU;
        else if (cnt_reg != '0)
          cnt_reg <= cnt_reg - 1'b1;
      end
      assign busy[gi] = (cnt_reg != '0);
    end
  endgenerate

  assign data_hazard = bus.id_valid && ((reads_rs1 && busy[rs1]) || (reads_rs2 && busy[rs2]));
  assign stall       = data_hazard || (state_reg == BUSY);
  // A branch can only resolve while EX is not held by a MUL.
  assign flush       = bus.ex_branch_taken && (state_reg == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      mcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mcnt_reg  <= mcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mcnt_next  = mcnt_reg;
    case (state_reg)
      IDLE: if (issue_int && is_mul) begin
        state_next = BUSY;
        mcnt_next  = MCNT_INIT;
      end
      BUSY: begin
        mcnt_next = mcnt_reg - 1'b1;
        if (mcnt_reg == MC_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.pc_write_en    = 1'b1;
    bus.if_id_write_en = 1'b1;
    bus.if_id_flush    = 1'b0;
    bus.id_ex_bubble   = 1'b0;
    bus.ex_hold        = (state_reg == BUSY);
    issue_int          = 1'b0;
    if (reset) begin
      bus.pc_write_en    = 1'b0;
      bus.if_id_write_en = 1'b0;
      bus.id_ex_bubble   = 1'b1;
      bus.ex_hold        = 1'b0;
    end else if (flush) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
    end else if (stall) begin
      bus.pc_write_en    = 1'b0;
      bus.if_id_write_en = 1'b0;
      bus.id_ex_bubble   = 1'b1;
    end else begin
      issue_int = bus.id_valid;
    end
  end

  assign bus.issue = issue_int;

  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt_reg <= '0;
    else if (stall && !flush && stall_cnt_reg != '1)
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign bus.stall_cycles = stall_cnt_reg;
endmodule
